// File: rtl/id_fwd_hazard_ctrl_pkg.sv
// Shared encodings for the ID-stage forwarding and hazard controller.
package id_fwd_hazard_ctrl_pkg;

  // Forwarding mux select codes for the ID-stage rs/rt operand muxes
  localparam logic [2:0] FSEL_RF        = 3'd0;
  localparam logic [2:0] FSEL_IDEX_PC4  = 3'd1;
  localparam logic [2:0] FSEL_EXMEM_RES = 3'd2;
  localparam logic [2:0] FSEL_EXMEM_PC4 = 3'd3;
  localparam logic [2:0] FSEL_WB        = 3'd4;

  // Kind of result a pipeline stage will write back
  localparam logic [1:0] WBSEL_ALU  = 2'd0;
  localparam logic [1:0] WBSEL_LOAD = 2'd1;
  localparam logic [1:0] WBSEL_LINK = 2'd2;

  // Multiply/divide unit start codes carried by the EX instruction
  localparam logic [1:0] MDU_NONE   = 2'd0;
  localparam logic [1:0] MDU_MULT   = 2'd1;
  localparam logic [1:0] MDU_DIV    = 2'd2;
  localparam logic [1:0] MDU_MTHILO = 2'd3;

  // Stall cause, also used as the controller state encoding
  typedef enum logic [1:0] {
    STALL_RUN  = 2'd0,
    STALL_DATA = 2'd1,
    STALL_MDU  = 2'd2
  } stall_cause_e;

  // True for the start codes that begin a multi-cycle HI/LO computation
  function automatic logic mdu_starts_op(input logic [1:0] start);
    return (start == MDU_MULT) || (start == MDU_DIV);
  endfunction

endpackage

// File: rtl/id_fwd_hazard_ctrl_if.sv
// Pipeline-side bundle of the ID forwarding/hazard controller.
// The master is the pipeline (supplies stage info), the slave is the controller.
interface id_fwd_hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       IF_ID_rs;
  logic [4:0]       IF_ID_rt;
  logic             ID_use_rs;
  logic             ID_use_rt;
  logic             ID_use_hilo;
  logic             ID_EX_RegWrite;
  logic [4:0]       ID_EX_rd;
  logic [1:0]       ID_EX_WBSel;
  logic [1:0]       ID_EX_MDU_start;
  logic             EX_MEM_RegWrite;
  logic [4:0]       EX_MEM_rd;
  logic [1:0]       EX_MEM_WBSel;
  logic             MEM_WB_RegWrite;
  logic [4:0]       MEM_WB_rd;

  logic [2:0]       IF_ID_rs_FUnit_o;
  logic [2:0]       IF_ID_rt_FUnit_o;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             ID_EX_Flush;
  logic [1:0]       stall_cause;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output IF_ID_rs, IF_ID_rt, ID_use_rs, ID_use_rt, ID_use_hilo,
           ID_EX_RegWrite, ID_EX_rd, ID_EX_WBSel, ID_EX_MDU_start,
           EX_MEM_RegWrite, EX_MEM_rd, EX_MEM_WBSel,
           MEM_WB_RegWrite, MEM_WB_rd,
    input  IF_ID_rs_FUnit_o, IF_ID_rt_FUnit_o, PC_Write, IF_ID_Write,
           ID_EX_Flush, stall_cause, mdu_busy, stall_cnt
  );

  modport slave (
    input  IF_ID_rs, IF_ID_rt, ID_use_rs, ID_use_rt, ID_use_hilo,
           ID_EX_RegWrite, ID_EX_rd, ID_EX_WBSel, ID_EX_MDU_start,
           EX_MEM_RegWrite, EX_MEM_rd, EX_MEM_WBSel,
           MEM_WB_RegWrite, MEM_WB_rd,
    output IF_ID_rs_FUnit_o, IF_ID_rt_FUnit_o, PC_Write, IF_ID_Write,
           ID_EX_Flush, stall_cause, mdu_busy, stall_cnt
  );

endinterface

// File: rtl/id_fwd_hazard_ctrl_fwd_sel_calc.sv
// Per-operand forwarding select and unresolvable data hazard decode.
module fwd_sel_calc
  import id_fwd_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       used,
  input  logic       idex_we,
  input  logic [4:0] idex_rd,
  input  logic [1:0] idex_wbsel,
  input  logic       exmem_we,
  input  logic [4:0] exmem_rd,
  input  logic [1:0] exmem_wbsel,
  input  logic       memwb_we,
  input  logic [4:0] memwb_rd,
  output logic [2:0] fsel,
  output logic       data_haz
);

  logic idex_hit;
  logic exmem_hit;
  logic memwb_hit;

  // Youngest producer wins; a youngest match that cannot be forwarded yet is a hazard
  always_comb begin
    idex_hit  = used && (src != 5'd0) && idex_we  && (idex_rd  == src);
    exmem_hit = used && (src != 5'd0) && exmem_we && (exmem_rd == src);
    memwb_hit = used && (src != 5'd0) && memwb_we && (memwb_rd == src);

    fsel = FSEL_RF;
    if (idex_hit && (idex_wbsel == WBSEL_LINK))
      fsel = FSEL_IDEX_PC4;
    else if (exmem_hit && (exmem_wbsel == WBSEL_LINK))
      fsel = FSEL_EXMEM_PC4;
    else if (exmem_hit && (exmem_wbsel == WBSEL_ALU))
      fsel = FSEL_EXMEM_RES;
    else if (memwb_hit)
      fsel = FSEL_WB;

    data_haz = 1'b0;
    if (idex_hit)
      data_haz = (idex_wbsel == WBSEL_ALU) || (idex_wbsel == WBSEL_LOAD);
    else if (exmem_hit)
      data_haz = (exmem_wbsel == WBSEL_LOAD);
  end

endmodule

// File: rtl/id_fwd_hazard_ctrl.sv
// ID-stage forwarding select, stall control, MDU busy tracking and stall statistics.
module id_fwd_hazard_ctrl
  import id_fwd_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  id_fwd_hazard_ctrl_if.slave bus
);

  localparam int MDU_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int MDU_W   = $clog2(MDU_MAX + 1);

  logic [MDU_W-1:0] mdu_cnt;
  logic [CNT_W-1:0] stall_cnt;
  stall_cause_e     state;
  stall_cause_e     state_next;
  logic             rs_haz;
  logic             rt_haz;
  logic             data_haz;
  logic             mdu_haz;
  logic             busy;
  logic             stall;

  fwd_sel_calc u_rs_sel (
    .src         (bus.IF_ID_rs),
    .used        (bus.ID_use_rs),
    .idex_we     (bus.ID_EX_RegWrite),
    .idex_rd     (bus.ID_EX_rd),
    .idex_wbsel  (bus.ID_EX_WBSel),
    .exmem_we    (bus.EX_MEM_RegWrite),
    .exmem_rd    (bus.EX_MEM_rd),
    .exmem_wbsel (bus.EX_MEM_WBSel),
    .memwb_we    (bus.MEM_WB_RegWrite),
    .memwb_rd    (bus.MEM_WB_rd),
    .fsel        (bus.IF_ID_rs_FUnit_o),
    .data_haz    (rs_haz)
  );

  fwd_sel_calc u_rt_sel (
    .src         (bus.IF_ID_rt),
    .used        (bus.ID_use_rt),
    .idex_we     (bus.ID_EX_RegWrite),
    .idex_rd     (bus.ID_EX_rd),
    .idex_wbsel  (bus.ID_EX_WBSel),
    .exmem_we    (bus.EX_MEM_RegWrite),
    .exmem_rd    (bus.EX_MEM_rd),
    .exmem_wbsel (bus.EX_MEM_WBSel),
    .memwb_we    (bus.MEM_WB_RegWrite),
    .memwb_rd    (bus.MEM_WB_rd),
    .fsel        (bus.IF_ID_rt_FUnit_o),
    .data_haz    (rt_haz)
  );

  // Combine hazards into the stall decision; reset forces the pipeline to run freely
  always_comb begin
    busy     = rst_n && (mdu_cnt != '0);
    data_haz = rs_haz || rt_haz;
    mdu_haz  = bus.ID_use_hilo && (busy || mdu_starts_op(bus.ID_EX_MDU_start));
    stall    = rst_n && (data_haz || mdu_haz);

    bus.PC_Write    = !stall;
    bus.IF_ID_Write = !stall;
    bus.ID_EX_Flush = stall;
    bus.mdu_busy    = busy;
    bus.stall_cause = state;
    bus.stall_cnt   = stall_cnt;
  end

  // Remaining HI/LO latency; a new start always restarts the window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mdu_cnt <= '0;
    end else begin
      case (bus.ID_EX_MDU_start)
        MDU_MULT:   mdu_cnt <= MDU_W'(MULT_LAT - 1);
        MDU_DIV:    mdu_cnt <= MDU_W'(DIV_LAT - 1);
        MDU_MTHILO: mdu_cnt <= '0;
        MDU_NONE: begin
          if (mdu_cnt != '0)
            mdu_cnt <= mdu_cnt - MDU_W'(1);
        end
      endcase
    end
  end

  // Stall-cause state register
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= STALL_RUN;
    else
      state <= state_next;
  end

  // Next stall cause: data hazards take precedence over MDU waits
  always_comb begin
    state_next = state;
    case (state)
      STALL_RUN: begin
        if (data_haz)
          state_next = STALL_DATA;
        else if (mdu_haz)
          state_next = STALL_MDU;
      end
      STALL_DATA, STALL_MDU: begin
        if (!stall)
          state_next = STALL_RUN;
        else if (data_haz)
          state_next = STALL_DATA;
        else
          state_next = STALL_MDU;
      end
      default: state_next = STALL_RUN;
    endcase
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_fwd_hazard_ctrl.sv
// Self-checking bench for id_fwd_hazard_ctrl: directed scenarios plus random traffic
// compared against a cycle-level reference model of the forwarding/stall rules.
module tb_id_fwd_hazard_ctrl;
  import id_fwd_hazard_ctrl_pkg::*;

  localparam int MULT_LAT  = 4;
  localparam int DIV_LAT   = 32;
  localparam int CNT_W     = 6;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  id_fwd_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  id_fwd_hazard_ctrl #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   nCompared;
  int   nMismatched;
  int   cyc;
  int   readyAt;
  int   mCause;
  int   mStallCnt;
  logic mLastStall;

  // Free-running pipeline clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck simulation
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setIdle();
    bus.IF_ID_rs        = 5'd0;
    bus.IF_ID_rt        = 5'd0;
    bus.ID_use_rs       = 1'b0;
    bus.ID_use_rt       = 1'b0;
    bus.ID_use_hilo     = 1'b0;
    bus.ID_EX_RegWrite  = 1'b0;
    bus.ID_EX_rd        = 5'd0;
    bus.ID_EX_WBSel     = 2'd0;
    bus.ID_EX_MDU_start = 2'd0;
    bus.EX_MEM_RegWrite = 1'b0;
    bus.EX_MEM_rd       = 5'd0;
    bus.EX_MEM_WBSel    = 2'd0;
    bus.MEM_WB_RegWrite = 1'b0;
    bus.MEM_WB_rd       = 5'd0;
  endtask

  // Which source feeds the operand: the newest stage holding a usable value for it
  function automatic logic [2:0] modelSel(input logic [4:0] src, input logic used);
    if (!used || src == 5'd0) return 3'd0;
    if (bus.ID_EX_RegWrite && bus.ID_EX_rd == src && bus.ID_EX_WBSel == 2'd2) return 3'd1;
    if (bus.EX_MEM_RegWrite && bus.EX_MEM_rd == src) begin
      if (bus.EX_MEM_WBSel == 2'd2) return 3'd3;
      if (bus.EX_MEM_WBSel == 2'd0) return 3'd2;
    end
    if (bus.MEM_WB_RegWrite && bus.MEM_WB_rd == src) return 3'd4;
    return 3'd0;
  endfunction

  // The newest in-flight producer of src decides whether its value exists yet
  function automatic logic modelHaz(input logic [4:0] src, input logic used);
    if (!used || src == 5'd0) return 1'b0;
    if (bus.ID_EX_RegWrite && bus.ID_EX_rd == src)
      return (bus.ID_EX_WBSel == 2'd0) || (bus.ID_EX_WBSel == 2'd1);
    if (bus.EX_MEM_RegWrite && bus.EX_MEM_rd == src)
      return bus.EX_MEM_WBSel == 2'd1;
    return 1'b0;
  endfunction

  // One pipeline cycle: check at the falling edge, then advance the model at the rising edge
  task automatic applyStimulus(input string tag);
    logic busy, dHaz, mHaz, stall;
    @(negedge clk);
    busy  = rst_n && (cyc < readyAt);
    dHaz  = modelHaz(bus.IF_ID_rs, bus.ID_use_rs) || modelHaz(bus.IF_ID_rt, bus.ID_use_rt);
    mHaz  = bus.ID_use_hilo && (busy || bus.ID_EX_MDU_start == 2'd1 || bus.ID_EX_MDU_start == 2'd2);
    stall = rst_n && (dHaz || mHaz);
    checkOutput({tag, ".rs_sel"},   32'(bus.IF_ID_rs_FUnit_o), 32'(modelSel(bus.IF_ID_rs, bus.ID_use_rs)));
    checkOutput({tag, ".rt_sel"},   32'(bus.IF_ID_rt_FUnit_o), 32'(modelSel(bus.IF_ID_rt, bus.ID_use_rt)));
    checkOutput({tag, ".pc_write"}, 32'(bus.PC_Write),    32'(!stall));
    checkOutput({tag, ".ifid_wr"},  32'(bus.IF_ID_Write), 32'(!stall));
    checkOutput({tag, ".flush"},    32'(bus.ID_EX_Flush), 32'(stall));
    checkOutput({tag, ".mdu_busy"}, 32'(bus.mdu_busy),    32'(busy));
    checkOutput({tag, ".cause"},    32'(bus.stall_cause), 32'(mCause));
    checkOutput({tag, ".stall_cnt"},32'(bus.stall_cnt),   32'(mStallCnt));
    mLastStall = stall;
    @(posedge clk);
    if (!rst_n) begin
      readyAt   = 0;
      mCause    = 0;
      mStallCnt = 0;
    end else begin
      case (bus.ID_EX_MDU_start)
        2'd1:    readyAt = cyc + MULT_LAT;
        2'd2:    readyAt = cyc + DIV_LAT;
        2'd3:    readyAt = cyc;
        default: ;
      endcase
      mCause = !stall ? 0 : (dHaz ? 1 : 2);
      if (stall && mStallCnt < STALL_MAX) mStallCnt++;
    end
    cyc++;
    #1;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    cyc         = 0;
    readyAt     = 0;
    mCause      = 0;
    mStallCnt   = 0;
    mLastStall  = 1'b0;
    setIdle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset holds stall logic off even with hazards presented
    bus.ID_EX_RegWrite  = 1'b1;
    bus.ID_EX_rd        = 5'd5;
    bus.IF_ID_rs        = 5'd5;
    bus.ID_use_rs       = 1'b1;
    bus.ID_use_hilo     = 1'b1;
    bus.ID_EX_MDU_start = MDU_DIV;
    applyStimulus("rst");
    checkOutput("rst.pc_write_const", 32'(bus.PC_Write), 32'd1);

    // ALU producer in EX feeding a beq: stall, then forward from EX_MEM
    setIdle();
    rst_n = 1'b1;
    bus.ID_EX_RegWrite = 1'b1; bus.ID_EX_rd = 5'd5; bus.ID_EX_WBSel = WBSEL_ALU;
    bus.IF_ID_rs = 5'd5; bus.IF_ID_rt = 5'd6; bus.ID_use_rs = 1'b1; bus.ID_use_rt = 1'b1;
    applyStimulus("alu.ex");
    checkOutput("alu.cause_data", 32'(bus.stall_cause), 32'(STALL_DATA));
    bus.ID_EX_RegWrite = 1'b0;
    bus.EX_MEM_RegWrite = 1'b1; bus.EX_MEM_rd = 5'd5; bus.EX_MEM_WBSel = WBSEL_ALU;
    applyStimulus("alu.mem");
    checkOutput("alu.cause_run", 32'(bus.stall_cause), 32'(STALL_RUN));
    checkOutput("alu.rs_sel2", 32'(bus.IF_ID_rs_FUnit_o), 32'd2);

    // jal in EX feeding jr r31; an older load of r31 is shadowed
    setIdle();
    bus.ID_EX_RegWrite = 1'b1; bus.ID_EX_rd = 5'd31; bus.ID_EX_WBSel = WBSEL_LINK;
    bus.IF_ID_rs = 5'd31; bus.ID_use_rs = 1'b1;
    applyStimulus("link.ex");
    bus.EX_MEM_RegWrite = 1'b1; bus.EX_MEM_rd = 5'd31; bus.EX_MEM_WBSel = WBSEL_LOAD;
    applyStimulus("link.shadow");
    checkOutput("link.rs_sel1", 32'(bus.IF_ID_rs_FUnit_o), 32'd1);
    checkOutput("link.no_stall", 32'(bus.PC_Write), 32'd1);

    // Load in EX_MEM stalls; once in MEM_WB it forwards from write-back
    setIdle();
    bus.EX_MEM_RegWrite = 1'b1; bus.EX_MEM_rd = 5'd8; bus.EX_MEM_WBSel = WBSEL_LOAD;
    bus.MEM_WB_RegWrite = 1'b1; bus.MEM_WB_rd = 5'd8;
    bus.IF_ID_rs = 5'd8; bus.ID_use_rs = 1'b1;
    applyStimulus("load.mem");
    bus.EX_MEM_RegWrite = 1'b0;
    applyStimulus("load.wb");
    checkOutput("load.rs_sel4", 32'(bus.IF_ID_rs_FUnit_o), 32'd4);

    // Divide with mflo arriving three cycles later stalls for 29 cycles
    setIdle();
    rst_n = 1'b0;
    applyStimulus("div.rst");
    rst_n = 1'b1;
    bus.ID_EX_MDU_start = MDU_DIV;
    applyStimulus("div.issue");
    setIdle();
    applyStimulus("div.gap1");
    applyStimulus("div.gap2");
    bus.ID_use_hilo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus("div.wait");
      if (!mLastStall) break;
    end
    checkOutput("div.stall_cnt29", 32'(bus.stall_cnt), 32'd29);
    checkOutput("div.busy_clear", 32'(bus.mdu_busy), 32'd0);

    // Back-to-back long MDU waits drive the stall counter into saturation
    bus.ID_EX_MDU_start = MDU_DIV;
    applyStimulus("sat.div");
    bus.ID_EX_MDU_start = MDU_NONE;
    for (int i = 0; i < 40; i++) begin
      applyStimulus("sat.divwait");
      if (!mLastStall) break;
    end
    bus.ID_EX_MDU_start = MDU_MULT;
    applyStimulus("sat.mult");
    bus.ID_EX_MDU_start = MDU_NONE;
    for (int i = 0; i < 10; i++) begin
      applyStimulus("sat.multwait");
      if (!mLastStall) break;
    end
    checkOutput("sat.stall_cnt_max", 32'(bus.stall_cnt), 32'(STALL_MAX));

    // r0 is never forwarded nor a hazard source
    setIdle();
    bus.ID_EX_RegWrite = 1'b1;  bus.ID_EX_WBSel  = WBSEL_ALU;
    bus.EX_MEM_RegWrite = 1'b1; bus.EX_MEM_WBSel = WBSEL_LOAD;
    bus.MEM_WB_RegWrite = 1'b1;
    bus.ID_use_rs = 1'b1; bus.ID_use_rt = 1'b1;
    applyStimulus("r0");
    checkOutput("r0.rs_sel0", 32'(bus.IF_ID_rs_FUnit_o), 32'd0);
    checkOutput("r0.rt_sel0", 32'(bus.IF_ID_rt_FUnit_o), 32'd0);

    // Reset in the middle of a divide wait aborts the busy window
    setIdle();
    bus.ID_EX_MDU_start = MDU_DIV;
    applyStimulus("abort.issue");
    setIdle();
    bus.ID_use_hilo = 1'b1;
    applyStimulus("abort.wait1");
    applyStimulus("abort.wait2");
    rst_n = 1'b0;
    applyStimulus("abort.rst");
    rst_n = 1'b1;
    applyStimulus("abort.after");
    checkOutput("abort.busy0", 32'(bus.mdu_busy), 32'd0);
    checkOutput("abort.cnt0", 32'(bus.stall_cnt), 32'd0);
    checkOutput("abort.cause_run", 32'(bus.stall_cause), 32'(STALL_RUN));

    // Random traffic over a small register window to provoke frequent matches
    for (int i = 0; i < 400; i++) begin
      rst_n               = ($urandom_range(0, 49) != 0);
      bus.IF_ID_rs        = 5'($urandom_range(0, 3));
      bus.IF_ID_rt        = 5'($urandom_range(0, 3));
      bus.ID_use_rs       = 1'($urandom_range(0, 1));
      bus.ID_use_rt       = 1'($urandom_range(0, 1));
      bus.ID_use_hilo     = ($urandom_range(0, 3) == 0);
      bus.ID_EX_RegWrite  = 1'($urandom_range(0, 1));
      bus.ID_EX_rd        = 5'($urandom_range(0, 3));
      bus.ID_EX_WBSel     = 2'($urandom_range(0, 3));
      bus.ID_EX_MDU_start = ($urandom_range(0, 9) < 2) ? 2'($urandom_range(0, 3)) : MDU_NONE;
      bus.EX_MEM_RegWrite = 1'($urandom_range(0, 1));
      bus.EX_MEM_rd       = 5'($urandom_range(0, 3));
      bus.EX_MEM_WBSel    = 2'($urandom_range(0, 3));
      bus.MEM_WB_RegWrite = 1'($urandom_range(0, 1));
      bus.MEM_WB_rd       = 5'($urandom_range(0, 3));
      applyStimulus("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/id_fwd_hazard_ctrl.md
Name: id_fwd_hazard_ctrl

Overview:
- Controller for the ID-stage operand forwarding muxes (rs and rt) of the 5-stage MIPS pipeline; drives their 3-bit select codes.
- Detects hazards that forwarding cannot resolve (load-use, ALU result not yet ready for branch/jr compare, HI/LO read while multiply/divide busy) and stalls PC/IF_ID while inserting ID_EX bubbles.
- Keeps the multiply/divide busy counter, a stall-cause state machine and a saturating stall-cycle counter.

Parameters:
- MULT_LAT, 4, cycles from mult/multu issue in EX until HI/LO valid
- DIV_LAT, 32, cycles from div/divu issue in EX until HI/LO valid
- CNT_W, 32, stall-cycle counter width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- IF_ID_rs  in  5  rs field of the instruction in ID
- IF_ID_rt  in  5  rt field of the instruction in ID
- ID_use_rs  in  1  ID instruction reads rs in ID (branch/jr/jalr)
- ID_use_rt  in  1  ID instruction reads rt in ID (beq/bne)
- ID_use_hilo  in  1  ID instruction is mfhi/mflo
- ID_EX_RegWrite  in  1  EX instruction writes the register file
- ID_EX_rd  in  5  EX destination register
- ID_EX_WBSel  in  2  EX result kind: 0 ALU/mult, 1 load, 2 link (PC+4)
- ID_EX_MDU_start  in  2  0 none, 1 mult/multu, 2 div/divu, 3 mthi/mtlo
- EX_MEM_RegWrite  in  1
- EX_MEM_rd  in  5
- EX_MEM_WBSel  in  2  encoding as ID_EX_WBSel
- MEM_WB_RegWrite  in  1
- MEM_WB_rd  in  5
- IF_ID_rs_FUnit_o  out  3  rs forwarding select
- IF_ID_rt_FUnit_o  out  3  rt forwarding select
- PC_Write  out  1  0 holds PC
- IF_ID_Write  out  1  0 holds IF_ID
- ID_EX_Flush  out  1  1 loads a bubble into ID_EX
- stall_cause  out  2  registered: 0 RUN, 1 DATA, 2 MDU
- mdu_busy  out  1  multiply/divide in progress
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Select codes: 0 RegFile, 1 ID_EX_PCPlusBy4, 2 EX_MEM_Mult_Mux_o, 3 EX_MEM_PCPlusBy4, 4 WBSrc_Mux_o. Codes 5-7 are never driven.
- Selects are combinational, computed identically for rs and rt. Source register 0, or the operand not used in ID, gives code 0.
- Priority is youngest first:
  - ID_EX match with WBSel=2 gives 1.
  - Otherwise EX_MEM match: WBSel=2 gives 3, WBSel=0 gives 2.
  - Otherwise MEM_WB match gives 4.
  - Otherwise 0.
- A "match" requires the stage's RegWrite=1 and rd==src, with src != 0.
- data_haz, for any used operand:
  - ID_EX match with WBSel in {0,1}, or
  - EX_MEM match with WBSel=1 (load data not yet available).
  - A younger link match (code 1) shadows older hazards.
- mdu_haz = ID_use_hilo & (mdu_busy | ID_EX_MDU_start in {1,2}).
- stall = data_haz | mdu_haz. When stall=1: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Otherwise 1/1/0. Stall decode is combinational; no extra latency.
- MDU counter:
  - Start 1 loads MULT_LAT-1; start 2 loads DIV_LAT-1.
  - Decrements to 0; mdu_busy = (cnt != 0).
  - A start while busy reloads, so the new op restarts.
  - Start 3 (mthi/mtlo) clears cnt to 0.
  - Start 0 leaves cnt unchanged apart from the decrement.
- FSM (registered, drives stall_cause):
  - RUN goes to DATA if data_haz, else to MDU if mdu_haz.
  - DATA/MDU re-evaluate every cycle with the same priority (data first) and return to RUN when stall=0.
  - stall_cause reflects the state register, one cycle behind stall.
- stall_cnt increments on every cycle with stall=1 and saturates at all ones.
- Reset (rst_n=0 at a clk edge):
  - cnt=0, state=RUN, stall_cnt=0.
  - Mid-divide reset aborts the busy window.
  - Combinational outputs follow their inputs; during reset, stall and MDU logic are forced inactive (PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0, mdu_busy=0).

Decomposition:
- Shared package holds:
  - FSEL_* constants (RF=0, IDEX_PC4=1, EXMEM_RES=2, EXMEM_PC4=3, WB=4)
  - WBSEL_* constants (ALU=0, LOAD=1, LINK=2)
  - MDU_* start codes
  - STALL_* cause codes
- One sub-module, fwd_sel_calc: pure combinational per-operand select and hazard decode, instantiated twice (rs and rt).
- Counter and FSM stay in the top.

Test Plan:
- ALU in EX writes r5 (WBSel=0); beq in ID uses r5/r6 -> stall=1, PC_Write=0, ID_EX_Flush=1. Next cycle the producer is in EX_MEM -> rs select=2, stall=0, stall_cause=DATA then RUN.
- jal in EX writes r31 (WBSel=2); jr r31 in ID -> rs select=1, no stall. The same r31 also pending in EX_MEM as a load -> still select=1, stall=0 (youngest wins).
- lw r8 in EX_MEM, MEM_WB also writes r8 -> stall=1. Next cycle the load is in MEM_WB -> select=4, stall=0.
- div issued (start=2, DIV_LAT=32); mflo reaches ID 3 cycles later -> stall for exactly 29 cycles, stall_cause=MDU, mdu_busy=0 afterwards, stall_cnt=29.
- Source r0 with every stage writing r0 -> select=0 and stall=0. rst_n=0 during a divide wait -> next cycle mdu_busy=0, stall_cnt=0, stall_cause=RUN.
